seg7_capture_decoder: RTL

- Receive side of the 7-segment display interface: watches the 7-bit segment bus driven by the binary-to-7seg encoder and recovers the 3-bit value shown.
- Accepts a pattern only after it has been stable for a programmable number of cycles, so glitches during encoder input changes are filtered out.
- Flags patterns that are not legal digits and counts them.
- Sits in the parking system as a self-check monitor on the display path. It is also the scoreboard front end for encoder benches.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_stability_filter.sv | 95 +++++++++
 rtl/seg7_capture_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package : seg7_pkg
// Desc    : Shared 7-segment patterns, filter state type and pattern decoder.
// Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } seg7_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [2:0] value;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_to_bin(input logic [6:0] i_pat);
    seg7_dec_t d;
    d = '0;
    case (i_pat)
      SEG_0:     begin d.legal = 1'b1; d.value = 3'd0; end
      SEG_1:     begin d.legal = 1'b1; d.value = 3'd1; end
      SEG_2:     begin d.legal = 1'b1; d.value = 3'd2; end
      SEG_3:     begin d.legal = 1'b1; d.value = 3'd3; end
      SEG_4:     begin d.legal = 1'b1; d.value = 3'd4; end
      SEG_5:     begin d.legal = 1'b1; d.value = 3'd5; end
      SEG_6:     begin d.legal = 1'b1; d.value = 3'd6; end
      SEG_7:     begin d.legal = 1'b1; d.value = 3'd7; end
      SEG_BLANK: d.blank = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_stability_filter.sv
`default_nettype none
// ============================================================================
// Module : seg7_stability_filter
// Desc   : Registers the segment bus and strobes acceptance once a pattern has
//          been held for STABLE_CYCLES consecutive samples.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_stability_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_seg,
  output logic [6:0] o_seg_q,
  output logic       o_accept
);

  localparam int unsigned       c_CNT_W  = 8;
  localparam logic [c_CNT_W-1:0] c_STABLE = c_CNT_W'(STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
  localparam logic [6:0]        c_POL    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  logic [6:0]         w_seg_fix;
  logic [6:0]         r_seg_q;
  logic [6:0]         r_seg_p;
  logic [6:0]         r_acc_pat;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  seg7_state_e        r_state;
  seg7_state_e        w_state_nxt;
  logic               w_accept;

  assign w_seg_fix = i_seg ^ c_POL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_seg_q   <= '0;
      r_seg_p   <= '0;
      r_acc_pat <= SEG_BLANK;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seg_q <= w_seg_fix;
      r_seg_p <= r_seg_q;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_acc_pat <= r_seg_q;
      end
    end
  end

  // The counter holds how many consecutive cycles r_seg_q has shown its value
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = SETTLING;
        w_cnt_nxt   = '0;
      end
      SETTLING: begin
        w_cnt_nxt = (r_seg_q == r_seg_p) ? r_cnt + c_ONE : c_ONE;
        if (w_cnt_nxt == c_STABLE) begin
          w_accept    = 1'b1;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (r_seg_q != r_acc_pat) begin
          w_cnt_nxt = c_ONE;
          // A one-sample filter accepts the change straight from LOCKED
          if (c_ONE == c_STABLE) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = SETTLING;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_seg_q  = r_seg_q;
  assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module : seg7_capture_decoder
// Desc   : Recovers the 3-bit value from a filtered 7-segment bus and tracks
//          invalid patterns.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg,
  input  logic                 clr_err,
  output logic [2:0]           binary,
  output logic                 digit_valid,
  output logic                 blank,
  output logic                 update,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] c_CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] c_CNT_MAX = '1;

  logic [6:0]           w_seg_q;
  logic                 w_accept;
  seg7_dec_t            w_dec;
  logic                 w_invalid;

  logic [2:0]           r_binary;
  logic                 r_digit_valid;
  logic                 r_blank;
  logic                 r_update;
  logic                 r_err;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;

  seg7_stability_filter #(
    .STABLE_CYCLES  (STABLE_CYCLES),
    .ACTIVE_LOW_SEG (ACTIVE_LOW_SEG)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_seg    (seg),
    .o_seg_q  (w_seg_q),
    .o_accept (w_accept)
  );

  assign w_dec     = seg7_to_bin(w_seg_q);
  assign w_invalid = w_accept & ~w_dec.legal & ~w_dec.blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_binary      <= 3'd0;
      r_digit_valid <= 1'b0;
      r_blank       <= 1'b1;
      r_update      <= 1'b0;
      r_err         <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_update <= w_accept;
      r_err    <= w_invalid;
      // binary keeps the last legal digit across blank and invalid patterns
      if (w_accept) begin
        if (w_dec.legal) begin
          r_binary      <= w_dec.value;
          r_digit_valid <= 1'b1;
          r_blank       <= 1'b0;
        end else begin
          r_digit_valid <= 1'b0;
          r_blank       <= w_dec.blank;
        end
      end
      if (clr_err) begin
        r_err_count  <= '0;
        r_err_sticky <= w_invalid;
      end else if (w_invalid) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != c_CNT_MAX) begin
          r_err_count <= r_err_count + c_CNT_ONE;
        end
      end
    end
  end

  assign binary      = r_binary;
  assign digit_valid = r_digit_valid;
  assign blank       = r_blank;
  assign update      = r_update;
  assign err         = r_err;
  assign err_sticky  = r_err_sticky;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire
